// File: rtl/distribute_var_seq.sv
// 1-to-2 distribution node: delivers each accepted operand to the low
// and/or high port, with independent per-port valid/ready handshakes.
module distribute_var_seq #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data_bus,
    input  logic [1:0]              i_dest,
    output logic                    o_ready,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
    input  logic [1:0]              i_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOW   = 2'b01,
        HIGH  = 2'b10,
        BOTH  = 2'b11
    } pend_t;

    pend_t                 pend_q;
    pend_t                 pend_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [1:0]            done;
    logic                  accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= EMPTY;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    // A new operand may land on the edge where the last pending port drains.
    always_comb begin
        done    = pend_q & i_ready;
        o_ready = rst && i_en && ((pend_q & ~i_ready) == 2'b00);
        accept  = i_valid && o_ready;
        pend_d  = pend_q;
        data_d  = data_q;
        unique case (pend_q)
            EMPTY: pend_d = EMPTY;
            LOW:   if (done[0]) pend_d = EMPTY;
            HIGH:  if (done[1]) pend_d = EMPTY;
            BOTH: begin
                unique case (done)
                    2'b01:   pend_d = HIGH;
                    2'b10:   pend_d = LOW;
                    2'b11:   pend_d = EMPTY;
                    default: pend_d = BOTH;
                endcase
            end
            default: pend_d = EMPTY;
        endcase
        if (accept) begin
            pend_d = pend_t'(i_dest);
            data_d = i_data_bus;
        end
    end

    always_comb begin
        o_valid    = pend_q;
        o_data_bus = '0;
        if (pend_q[0]) o_data_bus[DATA_WIDTH-1:0] = data_q;
        if (pend_q[1]) o_data_bus[DATA_WIDTH+:DATA_WIDTH] = data_q;
    end

endmodule

// File: tb/tb_distribute_var_seq.sv
// Randomized and directed bench for distribute_var_seq using
// per-port delivery queues as the reference model.
module tb_distribute_var_seq;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic       i_valid;
    logic [3:0] i_data_bus;
    logic [1:0] i_dest;
    logic       o_ready;
    logic [1:0] o_valid;
    logic [7:0] o_data_bus;
    logic [1:0] i_ready;

    int checks = 0;
    int errors = 0;

    logic [3:0] ql[$];
    logic [3:0] qh[$];
    logic [1:0] exp_valid;
    logic [7:0] exp_bus;
    logic       exp_ready;

    distribute_var_seq #(.DATA_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .i_en(i_en),
        .i_valid(i_valid),
        .i_data_bus(i_data_bus),
        .i_dest(i_dest),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_data_bus(o_data_bus),
        .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs after the falling edge and derive model expectations.
    task automatic drive(input logic en, input logic v, input logic [3:0] d,
                         input logic [1:0] dst, input logic [1:0] rdy);
        @(negedge clk);
        i_en = en;
        i_valid = v;
        i_data_bus = d;
        i_dest = dst;
        i_ready = rdy;
        #1;
        exp_valid = {qh.size() != 0, ql.size() != 0};
        exp_bus = {(qh.size() != 0) ? qh[0] : 4'h0,
                   (ql.size() != 0) ? ql[0] : 4'h0};
        exp_ready = rst && en &&
                    (ql.size() == 0 || rdy[0]) &&
                    (qh.size() == 0 || rdy[1]);
    endtask

    // Each queued operand is delivered once per port; accept refills.
    task automatic tick();
        logic acc;
        acc = i_valid && exp_ready;
        @(posedge clk);
        if (ql.size() != 0 && i_ready[0]) void'(ql.pop_front());
        if (qh.size() != 0 && i_ready[1]) void'(qh.pop_front());
        if (acc && i_dest[0]) ql.push_back(i_data_bus);
        if (acc && i_dest[1]) qh.push_back(i_data_bus);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_en = 1'b1;
        i_valid = 1'b0;
        i_data_bus = 4'h0;
        i_dest = 2'b00;
        i_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 2'b00 || o_data_bus !== 8'h00 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: valid=%b bus=%h ready=%b want 00/00/0",
                     o_valid, o_data_bus, o_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 4'hC, 2'b11, 2'b00);
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b00);
        checks++;
        if (o_valid !== 2'b11 || o_data_bus !== 8'hCC) begin
            errors++;
            $display("FAIL reset_pre: valid=%b bus=%h want 11/cc",
                     o_valid, o_data_bus);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (o_valid !== 2'b00 || o_data_bus !== 8'h00 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b bus=%h ready=%b want 00/00/0",
                     o_valid, o_data_bus, o_ready);
        end
        ql.delete();
        qh.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unicast_low();
        drive(1, 1, 4'hA, 2'b01, 2'b11);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL uni_ready: got %b want 1", o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b01 || o_data_bus !== 8'h0A) begin
            errors++;
            $display("FAIL uni_out: valid=%b bus=%h want 01/0a", o_valid, o_data_bus);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b00) begin
            errors++;
            $display("FAIL uni_clear: valid=%b want 00", o_valid);
        end
        tick();
    endtask

    task automatic test_multicast_stall();
        drive(1, 1, 4'h5, 2'b11, 2'b01);
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b01);
        checks++;
        if (o_valid !== 2'b11 || o_data_bus !== 8'h55 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL mc_both: valid=%b bus=%h ready=%b want 11/55/0",
                     o_valid, o_data_bus, o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b01);
        checks++;
        if (o_valid !== 2'b10 || o_data_bus !== 8'h50 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL mc_stall: valid=%b bus=%h ready=%b want 10/50/0",
                     o_valid, o_data_bus, o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b10 || o_data_bus !== 8'h50 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mc_release: valid=%b bus=%h ready=%b want 10/50/1",
                     o_valid, o_data_bus, o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b00) begin
            errors++;
            $display("FAIL mc_drained: valid=%b want 00", o_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[3];
        want[0] = 8'h10;
        want[1] = 8'h20;
        want[2] = 8'h30;
        drive(1, 1, 4'h1, 2'b10, 2'b11);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, i < 2, 4'(i + 2), 2'b10, 2'b11);
            checks++;
            if (o_valid !== 2'b10 || o_data_bus !== want[i] || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b bus=%h ready=%b want 10/%h/1",
                         i, o_valid, o_data_bus, o_ready, want[i]);
            end
            tick();
        end
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: valid=%b want 00", o_valid);
        end
        tick();
    endtask

    task automatic test_enable();
        drive(1, 1, 4'h7, 2'b01, 2'b00);
        tick();
        drive(0, 1, 4'h9, 2'b11, 2'b01);
        checks++;
        if (o_valid !== 2'b01 || o_data_bus !== 8'h07 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_drain: valid=%b bus=%h ready=%b want 01/07/0",
                     o_valid, o_data_bus, o_ready);
        end
        tick();
        drive(0, 1, 4'h9, 2'b11, 2'b01);
        checks++;
        if (o_valid !== 2'b00 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_ignore: valid=%b ready=%b want 00/0", o_valid, o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b00) begin
            errors++;
            $display("FAIL en_after: valid=%b want 00", o_valid);
        end
        tick();
    endtask

    task automatic test_null_mask();
        drive(1, 1, 4'hF, 2'b00, 2'b00);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL null_ready: got %b want 1", o_ready);
        end
        tick();
        drive(1, 0, 4'h0, 2'b00, 2'b00);
        checks++;
        if (o_valid !== 2'b00 || o_data_bus !== 8'h00) begin
            errors++;
            $display("FAIL null_out: valid=%b bus=%h want 00/00", o_valid, o_data_bus);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(7) != 0), 1'($urandom),
                  4'($urandom), 2'($urandom), 2'($urandom));
            checks++;
            if (o_valid !== exp_valid || o_data_bus !== exp_bus ||
                o_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_%0d: valid=%b bus=%h ready=%b want %b/%h/%b",
                         i, o_valid, o_data_bus, o_ready,
                         exp_valid, exp_bus, exp_ready);
            end
            tick();
        end
        repeat (2) begin
            drive(1, 0, 4'h0, 2'b00, 2'b11);
            tick();
        end
        drive(1, 0, 4'h0, 2'b00, 2'b11);
        checks++;
        if (o_valid !== 2'b00 || ql.size() != 0 || qh.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: valid=%b lowq=%0d highq=%0d want 00/0/0",
                     o_valid, ql.size(), qh.size());
        end
    endtask

    initial begin
        test_reset();
        test_unicast_low();
        test_multicast_stall();
        test_back_to_back();
        test_enable();
        test_null_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
